// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg: shared index types, FSM state and width helper for the outport scheduler
package chiplet_types_pkg;
   localparam int MAX_IDX_W = 8;
   typedef logic [MAX_IDX_W-1:0] buf_idx_t;
   typedef logic [MAX_IDX_W-1:0] outport_idx_t;
   typedef enum logic {IDLE, LOCKED} port_state_e;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
module rr_arbiter #(
   parameter int N = 5,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt
);
   // scan from farthest to nearest offset so the nearest requester wins last
   always_comb begin
      gnt = '0;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % N]) begin
            gnt = '0;
            gnt[(int'(ptr) + k) % N] = 1'b1;
         end
   end
endmodule

// File: rtl/outport_scheduler.sv
// outport_scheduler: per-outport wormhole lock, round-robin arbitration and credit tracking
module outport_scheduler
   import chiplet_types_pkg::*;
#(
   parameter int NUM_BUFFERS  = 5,
   parameter int NUM_OUTPORTS = 5,
   parameter int BUFFER_SIZE  = 8,
   localparam int BW = idx_w(NUM_BUFFERS),
   localparam int OW = idx_w(NUM_OUTPORTS),
   localparam int CW = idx_w(BUFFER_SIZE + 1)
) (
   input  logic                                 clk,
   input  logic                                 n_rst,
   input  logic [NUM_BUFFERS-1:0]               req_valid,
   input  logic [NUM_BUFFERS-1:0][OW-1:0]       req_outport,
   input  logic [NUM_BUFFERS-1:0]               req_tail,
   input  logic [NUM_OUTPORTS-1:0]              credit_granted,
   output logic [NUM_BUFFERS-1:0]               grant,
   output logic [NUM_OUTPORTS-1:0][BW-1:0]      select,
   output logic [NUM_OUTPORTS-1:0]              enable,
   output logic [NUM_OUTPORTS-1:0][CW-1:0]      credits,
   output logic [NUM_OUTPORTS-1:0]              credit_err
);
   for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_port
      port_state_e state, state_nxt;
      logic [BW-1:0] owner, rr_ptr, win;
      logic [NUM_BUFFERS-1:0] req, rr_gnt;
      logic [CW-1:0] cred;
      logic en, tail, cerr;
      // requesters whose head flit routes to this outport
      always_comb
         for (int i = 0; i < NUM_BUFFERS; i++)
            req[i] = req_valid[i] && (req_outport[i] == OW'(o));
      rr_arbiter #(.N(NUM_BUFFERS), .W(BW)) u_arb (
         .req (req),
         .ptr (rr_ptr),
         .gnt (rr_gnt)
      );
      // state register: lock, owner, round-robin pointer and credit counter
      always_ff @(posedge clk)
         if (n_rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cred   <= CW'(BUFFER_SIZE);
            cerr   <= 1'b0;
         end else begin
            state <= state_nxt;
            if (en && state == IDLE && !tail) owner <= win;
            if (en && tail) rr_ptr <= (win == BW'(NUM_BUFFERS - 1)) ? '0 : win + 1'b1;
            cred  <= (cred == CW'(BUFFER_SIZE) && !en) ? cred : cred - CW'(en) + CW'(credit_granted[o]);
            cerr  <= credit_granted[o] && !en && cred == CW'(BUFFER_SIZE);
         end
      // next state: a granted tail releases the port, a granted body flit holds it
      always_comb begin
         state_nxt = state;
         if (en) state_nxt = tail ? IDLE : LOCKED;
      end
      // outputs: locked ports only serve their owner; nothing moves without a credit
      always_comb begin
         win = '0;
         for (int i = 0; i < NUM_BUFFERS; i++)
            if (rr_gnt[i]) win = BW'(i);
         if (state == LOCKED) win = owner;
         en   = !n_rst && cred != '0 && (state == LOCKED ? req[owner] : |rr_gnt);
         tail = req_tail[win];
      end
      assign enable[o]     = en;
      assign select[o]     = en ? win : '0;
      assign credits[o]    = cred;
      assign credit_err[o] = cerr;
   end
   // a buffer pops when any enabled outport selects it
   always_comb begin
      grant = '0;
      for (int o = 0; o < NUM_OUTPORTS; o++)
         for (int i = 0; i < NUM_BUFFERS; i++)
            if (enable[o] && select[o] == BW'(i)) grant[i] = 1'b1;
   end
endmodule

// File: doc/outport_scheduler.md
OUTPORT_SCHEDULER -- requirements
Module: outport_scheduler

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 5, meaning number of input buffers (requesters).
REQ-002 SHALL have parameter NUM_OUTPORTS, default 5, meaning number of crossbar outputs.
REQ-003 SHALL have parameter BUFFER_SIZE, default 8, meaning downstream flit slots per outport (initial credits).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port n_rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_BUFFERS  head flit of buffer i is waiting.
REQ-007 SHALL have port req_outport  input  NUM_BUFFERS x clog2(NUM_OUTPORTS)  route-compute result for buffer i.
REQ-008 SHALL have port req_tail  input  NUM_BUFFERS  waiting flit of buffer i ends its packet.
REQ-009 SHALL have port credit_granted  input  NUM_OUTPORTS  downstream freed one slot on outport o.
REQ-010 SHALL have port grant  output  NUM_BUFFERS  buffer i pops its head flit this cycle.
REQ-011 SHALL have port select  output  NUM_OUTPORTS x clog2(NUM_BUFFERS)  crossbar input index for outport o.
REQ-012 SHALL have port enable  output  NUM_OUTPORTS  outport o drives a valid flit this cycle.
REQ-013 SHALL have port credits  output  NUM_OUTPORTS x clog2(BUFFER_SIZE+1)  current credit count per outport.
REQ-014 SHALL have port credit_err  output  NUM_OUTPORTS  one-cycle pulse: credit returned while counter full.

Function
REQ-015 grant/select/enable SHALL be combinational from current requests and registered state (0-cycle grant latency); all state updates on the clock edge of the grant.
REQ-016 Each outport SHALL run FSM IDLE/LOCKED with registered owner index and round-robin pointer rr_ptr.
REQ-017 IDLE: winner = first requester targeting o at or after rr_ptr (wrapping NUM_BUFFERS-1 to 0), only if credits[o] > 0.
REQ-018 IDLE grant with req_tail=0 SHALL go LOCKED, owner = winner; with req_tail=1 (single-flit packet) SHALL stay IDLE.
REQ-019 LOCKED: only owner may be granted (owner valid, targeting o, credits > 0); all other requesters to o SHALL be stalled.
REQ-020 LOCKED grant with req_tail=1 SHALL return to IDLE next cycle.
REQ-021 rr_ptr SHALL advance to (winner+1) mod NUM_BUFFERS on each tail grant only; unchanged otherwise.
REQ-022 Owner deasserting req_valid while LOCKED SHALL hold LOCKED with enable=0 (bubble), no reassignment.
REQ-023 enable[o]=1 iff some buffer granted to o; select[o] = that index, else 0.
REQ-024 grant[i] SHALL equal OR over o of (enable[o] and select[o]==i); at most one outport per buffer (guaranteed by single req_outport).
REQ-025 credits[o] next = credits - enable + credit_granted; simultaneous decrement and return SHALL leave it unchanged.
REQ-026 credit_granted at credits==BUFFER_SIZE with no enable SHALL saturate at BUFFER_SIZE and pulse credit_err[o].
REQ-027 credits[o]==0 SHALL block grant in both states; lock retained.

Reset
REQ-028 While n_rst=1 at a clock edge: all FSMs IDLE, owner=0, rr_ptr=0, credits=BUFFER_SIZE, credit_err=0.
REQ-029 While n_rst=1, grant, enable and select SHALL be forced 0 regardless of requests.
REQ-030 Reset asserted mid-packet SHALL drop the lock; no remaining flit state kept.

Structure
REQ-031 Shared package chiplet_types_pkg SHALL hold outport/buffer index typedefs; credit width derived locally from BUFFER_SIZE.
REQ-032 One sub-module SHALL be natural: rr_arbiter (NUM_BUFFERS-wide request, pointer in, one-hot grant out), instantiated per outport.

Verification (NUM_BUFFERS=4, NUM_OUTPORTS=4, BUFFER_SIZE=2)
REQ-033 Buffers 0,2 request outport 1, tail=1, held 4 cycles -> grants alternate 0,2,0,2; select[1]=0,2,0,2 with credits returned each cycle.
REQ-034 Buffer 3 sends 3-flit packet to outport 0 while buffer 1 also requests 0 -> buffer 3 granted 3 consecutive cycles, buffer 1 granted on 4th.
REQ-035 No credit returns, buffer 0 streams to outport 2 -> 2 grants, credits 2->1->0, then enable[2]=0 until credit_granted[2], then one grant.
REQ-036 enable[3] and credit_granted[3] same cycle at credits=1 -> credits stays 1; credit_granted[3] at credits=2 idle -> credits 2, credit_err[3]=1 one cycle.
REQ-037 Owner buffer 2 locked on outport 0 drops req_valid 2 cycles while buffer 0 requests 0 -> enable[0]=0 both cycles, buffer 0 ungranted.
REQ-038 n_rst=1 mid-packet on outport 1 -> next cycle IDLE, credits=2, outputs 0; after release, any requester granted from rr_ptr=0.
